// File: rtl/shift_pkg.sv
// Shared definitions for the PISO transmitter and its SIPO receiver:
// the state encoding, a constant clog2 helper and the default word width.
package shift_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Explicit encoding keeps the legacy IDLE=0 / SHIFT=1 state values.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a zero flag; used to frame words on both the
// transmit and receive sides.
module down_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out shift transmitter with valid/ready word intake,
// per-bit valid strobe and an end-of-word done pulse.
module piso_shift_tx
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             last;
  logic             accept;

  assign last       = (state == SHIFT) && cnt_zero;
  assign load_ready = !rst && ((state == IDLE) || last);
  assign accept     = load_valid && load_ready;
  assign done       = last;
  assign busy       = (state == SHIFT);
  assign sout_valid = (state == SHIFT);

  always_comb begin
    shreg_shifted = '0;
    sout          = 1'b0;
    if (LSB_FIRST) begin
      shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
      if (state == SHIFT) sout = shreg[0];
    end else begin
      shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
      if (state == SHIFT) sout = shreg[WIDTH-1];
    end
  end

  down_counter #(
    .W(CW)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .load_val(CW'(WIDTH - 1)),
    .dec     ((state == SHIFT) && !cnt_zero),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );

  // On the last bit a pending word reloads directly, giving a gapless
  // stream; otherwise the final shift leaves shreg all-zero for IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg <= din;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (accept) begin
            shreg <= din;
          end else begin
            shreg <= shreg_shifted;
            if (last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
